// File: rtl/hazard_controller.sv
// hazard_controller
//   Stall, flush and forwarding control for the F/D/E/M/W pipeline of the
//   cached RV32I core. It covers EX-stage forwarding select, load-use stall,
//   taken branch/jump flush, and a data-cache miss freeze controller. The
//   freeze controller has a miss timeout and a saturating stall-cycle counter.
//
// Ports
//   clk, rst_n                 rising-edge clock, async active-low reset
//   Rs1D, Rs2D                 decode-stage source registers
//   Rs1E, Rs2E, RdE            execute-stage sources / destination
//   RdM, RdW                   memory / writeback destinations
//   RegWriteM, RegWriteW       register-write enables
//   ResultSrcE                 2'b01 marks a load in E
//   PCSrcE                     taken branch/jump resolved in E
//   MemAccessM, CacheMissM     M-stage access and its cache-miss flag
//   CacheReadyM                refill-complete pulse
//   ForwardAE, ForwardBE       00 = RD1E/RD2E, 10 = ALUResultM, 01 = ResultW
//   StallF/D/E/M               hold stage register
//   FlushD/E/W                 clear stage register (FlushE drives E CLR)
//   MissTimeout                sticky miss-timeout error
//   StallCycles                saturating count of stalled cycles
module hazard_controller #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int MISS_TIMEOUT           = 64,
  parameter int PERF_WIDTH             = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW,
  input  logic                              RegWriteM,
  input  logic                              RegWriteW,
  input  logic [1:0]                        ResultSrcE,
  input  logic                              PCSrcE,
  input  logic                              MemAccessM,
  input  logic                              CacheMissM,
  input  logic                              CacheReadyM,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  output logic                              StallF,
  output logic                              StallD,
  output logic                              StallE,
  output logic                              StallM,
  output logic                              FlushD,
  output logic                              FlushE,
  output logic                              FlushW,
  output logic                              MissTimeout,
  output logic [PERF_WIDTH-1:0]             StallCycles
);

  localparam bit TIMEOUT_EN = (MISS_TIMEOUT != 0);
  localparam int CW = TIMEOUT_EN ? $clog2(MISS_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = TIMEOUT_EN ? CW'(MISS_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {RUN, MISS, RESUME} state_t;

  state_t        state;
  logic [CW-1:0] miss_cnt;
  logic          lw_stall;
  logic          freeze;

  function automatic logic [1:0] fwd_sel(input logic [REGISTER_ADDRESS_WIDTH-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs))      return 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == rs)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  // Outputs are combinational, so they are gated with rst_n to read as
  // all-zero for the whole time reset is held, not just after the first edge.
  always_comb begin
    lw_stall = rst_n && (ResultSrcE == 2'b01) && (RdE != '0) &&
               ((RdE == Rs1D) || (RdE == Rs2D));
    freeze   = rst_n && (((state == RUN) && MemAccessM && CacheMissM) ||
                         (state == MISS) || (state == RESUME));

    ForwardAE = rst_n ? fwd_sel(Rs1E) : 2'b00;
    ForwardBE = rst_n ? fwd_sel(Rs2E) : 2'b00;

    // Freeze holds every stage and bubbles W; the load-use/branch decision
    // is simply deferred because E is held and will be re-evaluated.
    StallF = freeze | lw_stall;
    StallD = freeze | lw_stall;
    StallE = freeze;
    StallM = freeze;
    FlushW = freeze;
    FlushD = rst_n && !freeze && PCSrcE;
    FlushE = rst_n && !freeze && (lw_stall || PCSrcE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      miss_cnt    <= '0;
      MissTimeout <= 1'b0;
      StallCycles <= '0;
    end else begin
      if ((freeze || lw_stall) && (StallCycles != '1))
        StallCycles <= StallCycles + 1'b1;

      unique case (state)
        RUN: begin
          if (MemAccessM && CacheMissM) begin
            state    <= MISS;
            miss_cnt <= '0;
          end
        end
        MISS: begin
          // With the timeout disabled the counter just wraps harmlessly.
          miss_cnt <= miss_cnt + 1'b1;
          if (CacheReadyM) begin
            state <= RESUME;
          end else if (TIMEOUT_EN && (miss_cnt == LAST_CNT)) begin
            state       <= RUN;
            MissTimeout <= 1'b1;
          end
        end
        RESUME:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Produces the stall, flush and forwarding controls consumed by the F/D/E/M/W pipeline registers of the cached RV32I core.
- Its FlushE output drives the execute register's CLR input.
- Combines load-use hazard detection, taken branch/jump flushing and EX-stage forwarding select.
- A sequential data-cache miss controller freezes the pipeline until the refill completes, with a miss timeout and a stall-cycle performance counter.

Parameters:
- REGISTER_ADDRESS_WIDTH, 5, register index width.
- MISS_TIMEOUT, 64, max cycles in MISS before abort; 0 disables the timeout.
- PERF_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D, Rs2D  in  REGISTER_ADDRESS_WIDTH  decode-stage source registers.
- Rs1E, Rs2E, RdE  in  REGISTER_ADDRESS_WIDTH  execute-stage sources and destination.
- RdM, RdW  in  REGISTER_ADDRESS_WIDTH  memory and writeback destinations.
- RegWriteM, RegWriteW  in  1  register-write enables, M and W stages.
- ResultSrcE  in  2  2'b01 = load in E.
- PCSrcE  in  1  taken branch/jump resolved in E.
- MemAccessM  in  1  load/store in M.
- CacheMissM  in  1  data-cache miss for the M access.
- CacheReadyM  in  1  refill complete (pulse).
- ForwardAE, ForwardBE  out  2  00 = RD1E/RD2E, 10 = ALUResultM, 01 = ResultW.
- StallF, StallD, StallE, StallM  out  1  hold stage register.
- FlushD, FlushE, FlushW  out  1  clear stage register (bubble).
- MissTimeout  out  1  sticky timeout error flag.
- StallCycles  out  PERF_WIDTH  count of stalled cycles.

Behaviour:
- Reset (rst_n low, async):
  - State = RUN, miss counter = 0, MissTimeout = 0, StallCycles = 0.
  - All stall/flush outputs forced 0; Forward* forced 00.
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
  - Else 01 if RegWriteW && RdW != 0 && RdW == Rs1E.
  - Else 00. M has priority over W.
  - ForwardBE uses the same rules with Rs2E.
  - Forwarding is unaffected by freeze.
- Load-use:
  - lwStall = (ResultSrcE == 01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
- Freeze (combinational):
  - freeze = (state == RUN && MemAccessM && CacheMissM) || state == MISS || state == RESUME.
- Output equations:
  - freeze = 1: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushD = FlushE = 0. Freeze overrides lwStall and PCSrcE; both are re-evaluated after release because E is held.
  - freeze = 0: StallF = StallD = lwStall, FlushE = lwStall | PCSrcE, FlushD = PCSrcE, StallE = StallM = FlushW = 0.
- FSM states:
  - RUN:
    - MemAccessM && CacheMissM -> MISS, counter = 0.
  - MISS:
    - Counter increments each cycle.
    - CacheReadyM -> RESUME. CacheReadyM wins over timeout in the same cycle.
    - Else if MISS_TIMEOUT != 0 and counter == MISS_TIMEOUT-1 -> RUN, MissTimeout <= 1.
    - CacheMissM is ignored in MISS.
  - RESUME:
    - One cycle of freeze so M captures the refilled data; -> RUN unconditionally.
    - CacheMissM is ignored in RESUME.
    - A new miss is only accepted in RUN; back-to-back misses therefore incur at least one RUN cycle between freezes.
- Counter width: $clog2(MISS_TIMEOUT+1), minimum 1.
- MissTimeout: cleared only by reset.
- StallCycles: increments every cycle with freeze | lwStall; saturates at all-ones, no wrap.
- Reset mid-miss: FSM returns to RUN immediately; freeze drops asynchronously.

Test Plan:
- Forwarding: RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10. With RdM = 0 -> ForwardAE = 01. With Rs2E = 0 and RdW = 0 -> ForwardBE = 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1, FlushD = 0, StallCycles +1. With RdE = 0 -> no stall.
- Branch: PCSrcE = 1 with no load hazard -> FlushD = FlushE = 1, StallF = 0. Same cycle also with lwStall -> FlushD = FlushE = StallF = StallD = 1.
- Cache miss: MemAccessM = CacheMissM = 1 at cycle 0, CacheReadyM pulse at cycle 10 -> StallF/D/E/M = FlushW = 1 from cycle 0 through cycle 11 (RESUME), released cycle 12. StallCycles = 12. PCSrcE = 1 during freeze -> FlushD = FlushE = 0.
- Timeout: MISS_TIMEOUT = 4, miss with no CacheReadyM -> freeze cycles 0–4, RUN at cycle 5, MissTimeout = 1 and stays 1. Repeat with CacheReadyM exactly at counter = 3 -> RESUME, MissTimeout = 0.
- Reset: assert rst_n = 0 in MISS at cycle 3 -> all outputs 0 immediately. After release, state RUN, StallCycles = 0. Saturation: preload a PERF_WIDTH = 4 build, 20 stall cycles -> StallCycles = 15.
